// File: rtl/rv32i_pkg.sv
// Shared RV32I constants and load-type encoding used by the writeback path.
package rv32i_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;
endpackage

// File: rtl/load_formatter.sv
// Selects the byte/half lane from an aligned load word and sign/zero extends it.
module load_formatter
  import rv32i_pkg::*;
(
  input  logic [2:0]      funct3_i,
  input  logic [1:0]      offset_i,
  input  logic [XLEN-1:0] raw_i,
  output logic [XLEN-1:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = raw_i[7:0];
    case (offset_i)
      2'd1:    byte_sel = raw_i[15:8];
      2'd2:    byte_sel = raw_i[23:16];
      2'd3:    byte_sel = raw_i[31:24];
      default: byte_sel = raw_i[7:0];
    endcase
    // Half lane only depends on offset[1]; misaligned bit 0 is ignored.
    half_sel = offset_i[1] ? raw_i[31:16] : raw_i[15:0];
  end

  always_comb begin
    data_o = '0;
    case (funct3_i)
      LB:      data_o = {{24{byte_sel[7]}}, byte_sel};
      LH:      data_o = {{16{half_sel[15]}}, half_sel};
      LW:      data_o = raw_i;
      LBU:     data_o = {24'd0, byte_sel};
      LHU:     data_o = {16'd0, half_sel};
      default: data_o = '0;
    endcase
  end
endmodule

// File: rtl/writeback_unit.sv
// Register-file write port driver: load/ALU arbitration, registered write,
// and a pending-load scoreboard feeding decode operand busy flags.
module writeback_unit
  import rv32i_pkg::*;
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_alu_valid,
  output logic                  o_alu_ready,
  input  logic [REG_ADDR_W-1:0] i_alu_rd,
  input  logic [XLEN-1:0]       i_alu_data,
  input  logic                  i_ld_valid,
  output logic                  o_ld_ready,
  input  logic [REG_ADDR_W-1:0] i_ld_rd,
  input  logic [2:0]            i_ld_funct3,
  input  logic [1:0]            i_ld_offset,
  input  logic [XLEN-1:0]       i_ld_rdata,
  input  logic                  i_ld_issue,
  input  logic [REG_ADDR_W-1:0] i_ld_issue_rd,
  input  logic [REG_ADDR_W-1:0] i_rs1_raddr,
  output logic                  o_rs1_busy,
  input  logic [REG_ADDR_W-1:0] i_rs2_raddr,
  output logic                  o_rs2_busy,
  output logic                  o_rd_wvalid,
  output logic [REG_ADDR_W-1:0] o_rd_waddr,
  output logic [XLEN-1:0]       o_rd_wdata
);
  logic                  wvalid_q, wvalid_d;
  logic [REG_ADDR_W-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]       wdata_q, wdata_d;
  logic [NREGS-1:0]      pending_q, pending_d;
  logic [XLEN-1:0]       ld_fmt;
  logic                  ld_acc, alu_acc;

  load_formatter u_fmt (
    .funct3_i (i_ld_funct3),
    .offset_i (i_ld_offset),
    .raw_i    (i_ld_rdata),
    .data_o   (ld_fmt)
  );

  // Loads always win; ALU is only offered the port when no load is presented.
  assign o_ld_ready  = rstn;
  assign o_alu_ready = rstn & ~i_ld_valid;
  assign ld_acc      = i_ld_valid & o_ld_ready;
  assign alu_acc     = i_alu_valid & o_alu_ready;

  always_comb begin
    wvalid_d = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    if (ld_acc) begin
      wvalid_d = (i_ld_rd != '0);
      waddr_d  = i_ld_rd;
      wdata_d  = ld_fmt;
    end else if (alu_acc) begin
      wvalid_d = (i_alu_rd != '0);
      waddr_d  = i_alu_rd;
      wdata_d  = i_alu_data;
    end
  end

  // Clear before set so a newly issued load to the same rd stays outstanding.
  always_comb begin
    pending_d = pending_q;
    if (ld_acc) pending_d[i_ld_rd] = 1'b0;
    if (i_ld_issue && i_ld_issue_rd != '0) pending_d[i_ld_issue_rd] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wvalid_q  <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      pending_q <= '0;
    end else begin
      wvalid_q  <= wvalid_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      pending_q <= pending_d;
    end
  end

  assign o_rd_wvalid = wvalid_q;
  assign o_rd_waddr  = waddr_q;
  assign o_rd_wdata  = wdata_q;

  // The in-flight write counts as busy until the register file commits it.
  assign o_rs1_busy = pending_q[i_rs1_raddr] |
                      (wvalid_q & (waddr_q == i_rs1_raddr) & (i_rs1_raddr != '0));
  assign o_rs2_busy = pending_q[i_rs2_raddr] |
                      (wvalid_q & (waddr_q == i_rs2_raddr) & (i_rs2_raddr != '0));
endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: load-format vector table plus handshake,
// scoreboard and async-reset sequences.
module tb_writeback_unit;
  logic        clk = 1'b0;
  logic        rstn;
  logic        i_alu_valid, o_alu_ready;
  logic [4:0]  i_alu_rd;
  logic [31:0] i_alu_data;
  logic        i_ld_valid, o_ld_ready;
  logic [4:0]  i_ld_rd;
  logic [2:0]  i_ld_funct3;
  logic [1:0]  i_ld_offset;
  logic [31:0] i_ld_rdata;
  logic        i_ld_issue;
  logic [4:0]  i_ld_issue_rd;
  logic [4:0]  i_rs1_raddr, i_rs2_raddr;
  logic        o_rs1_busy, o_rs2_busy;
  logic        o_rd_wvalid;
  logic [4:0]  o_rd_waddr;
  logic [31:0] o_rd_wdata;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .rstn(rstn),
    .i_alu_valid(i_alu_valid), .o_alu_ready(o_alu_ready),
    .i_alu_rd(i_alu_rd), .i_alu_data(i_alu_data),
    .i_ld_valid(i_ld_valid), .o_ld_ready(o_ld_ready),
    .i_ld_rd(i_ld_rd), .i_ld_funct3(i_ld_funct3),
    .i_ld_offset(i_ld_offset), .i_ld_rdata(i_ld_rdata),
    .i_ld_issue(i_ld_issue), .i_ld_issue_rd(i_ld_issue_rd),
    .i_rs1_raddr(i_rs1_raddr), .o_rs1_busy(o_rs1_busy),
    .i_rs2_raddr(i_rs2_raddr), .o_rs2_busy(o_rs2_busy),
    .o_rd_wvalid(o_rd_wvalid), .o_rd_waddr(o_rd_waddr), .o_rd_wdata(o_rd_wdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  off;
    logic [31:0] raw;
    logic [4:0]  rd;
    logic [31:0] exp;
  } fvec_t;

  fvec_t tbl[12];

  initial begin
    tbl[0]  = '{3'b000, 2'd3, 32'h80FF0011, 5'd1,  32'hFFFFFF80}; // LB
    tbl[1]  = '{3'b100, 2'd3, 32'h80FF0011, 5'd2,  32'h00000080}; // LBU
    tbl[2]  = '{3'b001, 2'd2, 32'h80FF0011, 5'd3,  32'hFFFF80FF}; // LH
    tbl[3]  = '{3'b101, 2'd2, 32'h80FF0011, 5'd4,  32'h000080FF}; // LHU
    tbl[4]  = '{3'b000, 2'd0, 32'h80FF0011, 5'd5,  32'h00000011};
    tbl[5]  = '{3'b000, 2'd1, 32'h80FF0011, 5'd6,  32'h00000000};
    tbl[6]  = '{3'b000, 2'd2, 32'h80FF0011, 5'd7,  32'hFFFFFFFF};
    tbl[7]  = '{3'b001, 2'd1, 32'h80FF8011, 5'd8,  32'hFFFF8011}; // offset[0] ignored
    tbl[8]  = '{3'b101, 2'd3, 32'h80FF0011, 5'd9,  32'h000080FF};
    tbl[9]  = '{3'b010, 2'd2, 32'h80FF0011, 5'd10, 32'h80FF0011}; // LW ignores offset
    tbl[10] = '{3'b011, 2'd0, 32'h80FF0011, 5'd11, 32'h00000000}; // illegal funct3
    tbl[11] = '{3'b100, 2'd2, 32'h80FF0011, 5'd31, 32'h000000FF};

    rstn = 1'b0;
    i_alu_valid = 0; i_alu_rd = 0; i_alu_data = 0;
    i_ld_valid = 0; i_ld_rd = 0; i_ld_funct3 = 0; i_ld_offset = 0; i_ld_rdata = 0;
    i_ld_issue = 0; i_ld_issue_rd = 0; i_rs1_raddr = 0; i_rs2_raddr = 0;

    #12;
    chk("rst_wvalid", {31'd0, o_rd_wvalid}, 32'd0);
    chk("rst_waddr", {27'd0, o_rd_waddr}, 32'd0);
    chk("rst_wdata", o_rd_wdata, 32'd0);
    chk("rst_alu_rdy", {31'd0, o_alu_ready}, 32'd0);
    chk("rst_ld_rdy", {31'd0, o_ld_ready}, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // ALU write
    @(negedge clk);
    i_alu_valid = 1; i_alu_rd = 5'd5; i_alu_data = 32'hDEADBEEF;
    #1 chk("alu_rdy", {31'd0, o_alu_ready}, 32'd1);
    chk("ld_rdy", {31'd0, o_ld_ready}, 32'd1);
    @(negedge clk);
    chk("alu_wvalid", {31'd0, o_rd_wvalid}, 32'd1);
    chk("alu_waddr", {27'd0, o_rd_waddr}, 32'd5);
    chk("alu_wdata", o_rd_wdata, 32'hDEADBEEF);
    i_alu_valid = 0;
    @(negedge clk);
    chk("idle_wvalid", {31'd0, o_rd_wvalid}, 32'd0);
    chk("idle_waddr_hold", {27'd0, o_rd_waddr}, 32'd5);
    chk("idle_wdata_hold", o_rd_wdata, 32'hDEADBEEF);

    // Simultaneous ALU and load: load first
    i_alu_valid = 1; i_alu_rd = 5'd3; i_alu_data = 32'hAAAA5555;
    i_ld_valid = 1; i_ld_rd = 5'd4; i_ld_funct3 = 3'b010; i_ld_offset = 0; i_ld_rdata = 32'h12345678;
    #1 chk("arb_alu_rdy", {31'd0, o_alu_ready}, 32'd0);
    @(negedge clk);
    chk("arb_ld_waddr", {27'd0, o_rd_waddr}, 32'd4);
    chk("arb_ld_wdata", o_rd_wdata, 32'h12345678);
    chk("arb_ld_wvalid", {31'd0, o_rd_wvalid}, 32'd1);
    i_ld_valid = 0;
    #1 chk("arb_alu_rdy2", {31'd0, o_alu_ready}, 32'd1);
    @(negedge clk);
    chk("arb_alu_waddr", {27'd0, o_rd_waddr}, 32'd3);
    chk("arb_alu_wdata", o_rd_wdata, 32'hAAAA5555);
    i_alu_valid = 0;

    // Load-format table, back-to-back accepts
    for (int i = 0; i < 12; i++) begin
      i_ld_valid = 1; i_ld_funct3 = tbl[i].f3; i_ld_offset = tbl[i].off;
      i_ld_rdata = tbl[i].raw; i_ld_rd = tbl[i].rd;
      @(negedge clk);
      chk($sformatf("fmt%0d_wvalid", i), {31'd0, o_rd_wvalid}, 32'd1);
      chk($sformatf("fmt%0d_waddr", i), {27'd0, o_rd_waddr}, {27'd0, tbl[i].rd});
      chk($sformatf("fmt%0d_wdata", i), o_rd_wdata, tbl[i].exp);
    end
    i_ld_valid = 0;
    @(negedge clk);

    // Scoreboard for rd=7
    i_ld_issue = 1; i_ld_issue_rd = 5'd7; i_rs1_raddr = 5'd7; i_rs2_raddr = 5'd8;
    @(negedge clk);
    i_ld_issue = 0;
    chk("sb_busy_set", {31'd0, o_rs1_busy}, 32'd1);
    chk("sb_other_clr", {31'd0, o_rs2_busy}, 32'd0);
    @(negedge clk);
    chk("sb_busy_hold", {31'd0, o_rs1_busy}, 32'd1);
    i_ld_valid = 1; i_ld_rd = 5'd7; i_ld_funct3 = 3'b010; i_ld_rdata = 32'h0BADF00D;
    @(negedge clk);
    i_ld_valid = 0;
    chk("sb_busy_wvalid", {31'd0, o_rs1_busy}, 32'd1);
    chk("sb_wvalid", {31'd0, o_rd_wvalid}, 32'd1);
    @(negedge clk);
    chk("sb_busy_done", {31'd0, o_rs1_busy}, 32'd0);

    // Set and clear of the same rd on one edge: set wins
    i_ld_issue = 1; i_ld_issue_rd = 5'd10; i_rs2_raddr = 5'd10;
    @(negedge clk);
    i_ld_valid = 1; i_ld_rd = 5'd10;
    @(negedge clk);
    i_ld_issue = 0; i_ld_valid = 0;
    @(negedge clk);
    chk("sb_set_wins", {31'd0, o_rs2_busy}, 32'd1);
    i_ld_valid = 1; i_ld_rd = 5'd10;
    @(negedge clk);
    i_ld_valid = 0;
    @(negedge clk);
    chk("sb_second_clr", {31'd0, o_rs2_busy}, 32'd0);

    // rd=0 traffic
    i_alu_valid = 1; i_alu_rd = 5'd0; i_alu_data = 32'h1;
    #1 chk("x0_alu_rdy", {31'd0, o_alu_ready}, 32'd1);
    @(negedge clk);
    i_alu_valid = 0;
    chk("x0_alu_nowrite", {31'd0, o_rd_wvalid}, 32'd0);
    i_ld_issue = 1; i_ld_issue_rd = 5'd0; i_rs1_raddr = 5'd0;
    @(negedge clk);
    i_ld_issue = 0;
    chk("x0_busy", {31'd0, o_rs1_busy}, 32'd0);
    i_ld_valid = 1; i_ld_rd = 5'd0;
    @(negedge clk);
    i_ld_valid = 0;
    chk("x0_ld_nowrite", {31'd0, o_rd_wvalid}, 32'd0);
    chk("x0_busy2", {31'd0, o_rs1_busy}, 32'd0);

    // Async reset with a write in flight and rd=9 pending
    i_ld_issue = 1; i_ld_issue_rd = 5'd9;
    i_alu_valid = 1; i_alu_rd = 5'd12; i_alu_data = 32'h5A5A5A5A;
    i_rs1_raddr = 5'd9; i_rs2_raddr = 5'd12;
    @(negedge clk);
    i_ld_issue = 0; i_alu_valid = 0;
    chk("pre_rst_wvalid", {31'd0, o_rd_wvalid}, 32'd1);
    chk("pre_rst_busy9", {31'd0, o_rs1_busy}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("arst_wvalid", {31'd0, o_rd_wvalid}, 32'd0);
    chk("arst_busy9", {31'd0, o_rs1_busy}, 32'd0);
    chk("arst_busy12", {31'd0, o_rs2_busy}, 32'd0);
    chk("arst_ld_rdy", {31'd0, o_ld_ready}, 32'd0);
    @(negedge clk); rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_rst_wvalid", {31'd0, o_rd_wvalid}, 32'd0);
    chk("post_rst_busy9", {31'd0, o_rs1_busy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
